// File: rtl/vdma_burst_arbiter.sv
// Shares one AXI burst engine between NUM VDMA requesters: tail requests first, then round-robin,
// with a watchdog that aborts a transfer the engine never accepts or never finishes.
module vdma_burst_arbiter #(
    parameter int          NUM     = 4,
    parameter int          LSIZE   = 9,
    parameter int          IDW     = 2,
    parameter logic [23:0] TIMEOUT = 24'hFFF000
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM-1:0]       burst_req,
    input  logic [NUM-1:0]       tail_req,
    input  logic [NUM*LSIZE-1:0] req_len,
    output logic [NUM-1:0]       resp,
    output logic [NUM-1:0]       done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [LSIZE-1:0]     cmd_len,
    output logic [IDW-1:0]       cmd_id,
    output logic                 cmd_tail,
    input  logic                 eng_done,
    output logic                 abort,
    output logic [IDW-1:0]       err_id,
    output logic [2:0]           state_dbg
);

    // Command handshake: cmd_valid rises with ISSUE and the cmd_* fields stay frozen until the
    // cycle in which cmd_valid & cmd_ready are both high; that cycle is the single transfer point.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        ZLEN  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   last, last_n;
    logic [23:0]      wdog, wdog_n;
    logic [NUM-1:0]   resp_n, done_n;
    logic             cmd_valid_n, cmd_tail_n, abort_n;
    logic [LSIZE-1:0] cmd_len_n;
    logic [IDW-1:0]   cmd_id_n, err_id_n, winner;
    logic             expired;

    // First set bit scanning ptr+1 .. ptr (mod NUM); descending loop lets the nearest hit win.
    function automatic logic [IDW-1:0] pick(input logic [NUM-1:0] v, input logic [IDW-1:0] ptr);
        int idx;
        pick = '0;
        for (int k = NUM; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM;
            if (v[idx]) pick = IDW'(idx);
        end
    endfunction

    always_comb begin
        state_n     = state;
        last_n      = last;
        wdog_n      = '0;
        resp_n      = '0;
        done_n      = '0;
        cmd_valid_n = 1'b0;
        cmd_len_n   = cmd_len;
        cmd_id_n    = cmd_id;
        cmd_tail_n  = cmd_tail;
        abort_n     = 1'b0;
        err_id_n    = err_id;
        winner      = pick((tail_req != '0) ? tail_req : burst_req, last);
        expired     = (TIMEOUT != 24'd0) && (wdog == TIMEOUT);

        case (state)
            IDLE: begin
                if (enable && ((burst_req | tail_req) != '0)) begin
                    cmd_id_n   = winner;
                    cmd_len_n  = req_len[int'(winner)*LSIZE +: LSIZE];
                    cmd_tail_n = tail_req[winner];
                    if (req_len[int'(winner)*LSIZE +: LSIZE] == '0) begin
                        state_n = ZLEN;
                    end else begin
                        state_n     = ISSUE;
                        cmd_valid_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                wdog_n = wdog + 24'd1;
                if (cmd_valid && cmd_ready) begin
                    resp_n[cmd_id] = 1'b1;
                    state_n        = BUSY;
                end else if (expired) begin
                    abort_n  = 1'b1;
                    err_id_n = cmd_id;
                    last_n   = cmd_id;
                    state_n  = IDLE;
                end else begin
                    cmd_valid_n = 1'b1;
                end
            end
            BUSY: begin
                wdog_n = wdog + 24'd1;
                if (eng_done) begin
                    done_n[cmd_id] = 1'b1;
                    state_n        = FIN;
                end else if (expired) begin
                    abort_n  = 1'b1;
                    err_id_n = cmd_id;
                    last_n   = cmd_id;
                    state_n  = IDLE;
                end
            end
            ZLEN: begin
                resp_n[cmd_id] = 1'b1;
                state_n        = FIN;
            end
            FIN: begin
                // A zero-length grant reaches FIN without a done; it is delivered here instead.
                if (cmd_len == '0) done_n[cmd_id] = 1'b1;
                last_n  = cmd_id;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(NUM - 1);
            wdog      <= '0;
            resp      <= '0;
            done      <= '0;
            cmd_valid <= 1'b0;
            cmd_len   <= '0;
            cmd_id    <= '0;
            cmd_tail  <= 1'b0;
            abort     <= 1'b0;
            err_id    <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            wdog      <= wdog_n;
            resp      <= resp_n;
            done      <= done_n;
            cmd_valid <= cmd_valid_n;
            cmd_len   <= cmd_len_n;
            cmd_id    <= cmd_id_n;
            cmd_tail  <= cmd_tail_n;
            abort     <= abort_n;
            err_id    <= err_id_n;
        end
    end

    assign state_dbg = state;

endmodule
